// File: rtl/tx_req_buffer_pkg.sv
// Shared types for the per-sub-AFU Tx request buffer: a minimal CCI-P Tx struct
// subset, the per-channel FIFO entry types, and pointer/count width helpers.
package tx_req_buffer_pkg;

  localparam int DEPTH_DEF = 32;
  localparam int SLACK_DEF = 8;

  typedef logic [511:0] t_ccip_clData;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    logic [1:0]   cl_len;
    logic [3:0]   req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    logic [1:0]   cl_len;
    logic [3:0]   req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef t_ccip_c0_ReqMemHdr t_tx_c0_entry;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
  } t_tx_c1_entry;

  localparam int TX_W = $bits(t_if_ccip_Tx);

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tx_req_buffer_fifo.sv
// One channel's request FIFO: push/pop bookkeeping, registered almFull from the
// next-state occupancy, and a combinational overflow event (push at full, no pop).
module tx_buf_fifo
  import tx_req_buffer_pkg::*;
#(
  parameter type T_ENTRY = logic,
  parameter int  DEPTH   = 32,
  parameter int  SLACK   = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_push,
  input  T_ENTRY i_din,
  input  logic   i_pop_en,
  output logic   o_pop,
  output T_ENTRY o_dout,
  output logic   o_alm_full,
  output logic   o_ovf
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_THRESH = CW'(DEPTH - SLACK);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  T_ENTRY        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_alm_full;
  logic [CW-1:0] w_count_next;
  logic          w_full;
  logic          w_wr;

  assign o_pop  = (r_count != '0) && i_pop_en;
  assign w_full = (r_count == FULL_CNT);
  // A same-edge pop frees the slot the push lands in, so full+pop still accepts.
  assign w_wr   = i_push && (!w_full || o_pop);
  assign o_ovf  = i_push && w_full && !o_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !o_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_wr && o_pop) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_alm_full <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (o_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count    <= w_count_next;
      r_alm_full <= (w_count_next >= AF_THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout     = r_mem[r_rd_ptr];
  assign o_alm_full = r_alm_full;

endmodule

// File: rtl/tx_req_buffer.sv
// Per-sub-AFU CCI-P Tx request buffer: c0/c1 FIFOs gated by mux almFull, c2 registered.
// Optional sticky overflow flag and assertion under TX_REQ_BUFFER_OVF_CHECK_EN.
module tx_req_buffer
  import tx_req_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SLACK = SLACK_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [TX_W-1:0] in,
  output logic [TX_W-1:0] out,
  input  logic            in_c0_almFull,
  input  logic            in_c1_almFull,
  output logic            out_c0_almFull,
  output logic            out_c1_almFull,
  output logic            ovf_err
);

  t_if_ccip_Tx    w_in;
  t_if_ccip_Tx    w_out;
  t_tx_c0_entry   w_c0_dout;
  t_tx_c1_entry   w_c1_din;
  t_tx_c1_entry   w_c1_dout;
  logic           w_c0_pop;
  logic           w_c1_pop;
  logic           w_c0_ovf;
  logic           w_c1_ovf;
  t_if_ccip_c0_Tx r_out_c0;
  t_if_ccip_c1_Tx r_out_c1;
  t_if_ccip_c2_Tx r_out_c2;

  assign w_in          = in;
  assign w_c1_din.hdr  = w_in.c1.hdr;
  assign w_c1_din.data = w_in.c1.data;

  tx_buf_fifo #(
    .T_ENTRY (t_tx_c0_entry),
    .DEPTH   (DEPTH),
    .SLACK   (SLACK)
  ) u_fifo_c0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_in.c0.valid),
    .i_din      (w_in.c0.hdr),
    .i_pop_en   (!in_c0_almFull),
    .o_pop      (w_c0_pop),
    .o_dout     (w_c0_dout),
    .o_alm_full (out_c0_almFull),
    .o_ovf      (w_c0_ovf)
  );

  tx_buf_fifo #(
    .T_ENTRY (t_tx_c1_entry),
    .DEPTH   (DEPTH),
    .SLACK   (SLACK)
  ) u_fifo_c1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_in.c1.valid),
    .i_din      (w_c1_din),
    .i_pop_en   (!in_c1_almFull),
    .o_pop      (w_c1_pop),
    .o_dout     (w_c1_dout),
    .o_alm_full (out_c1_almFull),
    .o_ovf      (w_c1_ovf)
  );

  // Payload fields are zeroed whenever the channel is not valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_c0 <= '0;
      r_out_c1 <= '0;
      r_out_c2 <= '0;
    end else begin
      r_out_c0.valid <= w_c0_pop;
      r_out_c0.hdr   <= w_c0_pop ? w_c0_dout : '0;
      r_out_c1.valid <= w_c1_pop;
      r_out_c1.hdr   <= w_c1_pop ? w_c1_dout.hdr : '0;
      r_out_c1.data  <= w_c1_pop ? w_c1_dout.data : '0;
      r_out_c2       <= w_in.c2;
    end
  end

  assign w_out.c0 = r_out_c0;
  assign w_out.c1 = r_out_c1;
  assign w_out.c2 = r_out_c2;
  assign out      = w_out;

`ifdef TX_REQ_BUFFER_OVF_CHECK_EN
  logic r_ovf_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_err <= 1'b0;
    end else if (w_c0_ovf || w_c1_ovf) begin
      r_ovf_err <= 1'b1;
    end
  end

  assign ovf_err = r_ovf_err;

  a_ovf_c0: assert property (@(posedge clk) disable iff (!reset_n) !w_c0_ovf)
    else $warning("tx_req_buffer overflow: channel %0d dropped a request", 0);
  a_ovf_c1: assert property (@(posedge clk) disable iff (!reset_n) !w_c1_ovf)
    else $warning("tx_req_buffer overflow: channel %0d dropped a request", 1);
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_c0_ovf | w_c1_ovf;
  assign ovf_err      = 1'b0;
`endif

endmodule
